// File: rtl/ysyx_23060286_core_seq.sv
// Multi-cycle control sequencer for the NPC core: IDLE/FETCH/DEC/EXE/MEM/WB/HALT with handshake watchdog.
// Optional NPC_PERF_CNT_EN adds 64-bit cycle and retired-instruction counters.
module ysyx_23060286_core_seq #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ifu_rvalid,
    input  logic [6:0]  op,
    input  logic        is_ebreak,
    input  logic        regwrite_dec,
    input  logic        lsu_done,
    output logic        ifu_req,
    output logic        ir_we,
    output logic        lsu_req,
    output logic        lsu_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        halt,
`ifdef NPC_PERF_CNT_EN
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_instret,
`endif
    output logic [1:0]  halt_code
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXE   = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_halt_code;
    logic [1:0]         w_code_nxt;
    logic [CNT_W-1:0]   r_wdog;
    logic               w_expired;
    logic               r_ifu_req;
    logic               r_lsu_req;
    logic               r_pc_we;
    logic               r_halt;

    function automatic logic legal_op(input logic [6:0] opc);
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_OPIMM, OP_STORE, OP_OP, OP_FENCE, OP_SYSTEM: legal_op = 1'b1;
            default:                                          legal_op = 1'b0;
        endcase
    endfunction

    assign w_expired = (r_wdog == CNT_W'(TIMEOUT - 1));

    // Next-state and halt-code selection; handshakes take priority over watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_halt_code;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
                else       w_state_nxt = S_IDLE;
            end
            S_FETCH: begin
                if (ifu_rvalid) begin
                    w_state_nxt = S_DEC;
                end else if (w_expired) begin
                    w_state_nxt = S_HALT;
                    w_code_nxt  = 2'b11;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DEC: begin
                if (is_ebreak) begin
                    w_state_nxt = S_HALT;
                    w_code_nxt  = 2'b01;
                end else if (!legal_op(op)) begin
                    w_state_nxt = S_HALT;
                    w_code_nxt  = 2'b10;
                end else begin
                    w_state_nxt = S_EXE;
                end
            end
            S_EXE: begin
                if (op == OP_LOAD || op == OP_STORE) w_state_nxt = S_MEM;
                else                                 w_state_nxt = S_WB;
            end
            S_MEM: begin
                if (lsu_done) begin
                    w_state_nxt = S_WB;
                end else if (w_expired) begin
                    w_state_nxt = S_HALT;
                    w_code_nxt  = 2'b11;
                end else begin
                    w_state_nxt = S_MEM;
                end
            end
            S_WB:    w_state_nxt = S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, watchdog and Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_halt_code <= 2'b00;
            r_wdog      <= '0;
            r_ifu_req   <= 1'b0;
            r_lsu_req   <= 1'b0;
            r_pc_we     <= 1'b0;
            r_halt      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_halt_code <= w_code_nxt;
            if (w_state_nxt != r_state) begin
                r_wdog <= '0;
            end else if (r_state == S_FETCH || r_state == S_MEM) begin
                r_wdog <= r_wdog + CNT_W'(1);
            end else begin
                r_wdog <= r_wdog;
            end
            r_ifu_req <= (w_state_nxt == S_FETCH);
            r_lsu_req <= (w_state_nxt == S_MEM);
            r_pc_we   <= (w_state_nxt == S_WB);
            r_halt    <= (w_state_nxt == S_HALT);
        end
    end

`ifdef NPC_PERF_CNT_EN
    logic [63:0] r_perf_cycles;
    logic [63:0] r_perf_instret;

    // Performance counters; both hold still in IDLE and HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles  <= 64'd0;
            r_perf_instret <= 64'd0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT) r_perf_cycles <= r_perf_cycles + 64'd1;
            else                                        r_perf_cycles <= r_perf_cycles;
            if (r_pc_we) r_perf_instret <= r_perf_instret + 64'd1;
            else         r_perf_instret <= r_perf_instret;
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_instret = r_perf_instret;
`endif

    assign ifu_req   = r_ifu_req;
    assign ir_we     = (r_state == S_FETCH) & ifu_rvalid;
    assign lsu_req   = r_lsu_req;
    assign lsu_we    = r_lsu_req & (op == OP_STORE);
    assign pc_we     = r_pc_we;
    assign rf_we     = r_pc_we & regwrite_dec;
    assign halt      = r_halt;
    assign halt_code = r_halt_code;

endmodule

// File: tb/tb_ysyx_23060286_core_seq.sv
// Directed bench for ysyx_23060286_core_seq built with TIMEOUT=8.
module tb_ysyx_23060286_core_seq;

    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ifu_rvalid = 1'b0;
    logic [6:0]  op = 7'd0;
    logic        is_ebreak = 1'b0;
    logic        regwrite_dec = 1'b0;
    logic        lsu_done = 1'b0;
    logic        ifu_req, ir_we, lsu_req, lsu_we, pc_we, rf_we, halt;
    logic [1:0]  halt_code;
`ifdef NPC_PERF_CNT_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060286_core_seq #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ifu_rvalid(ifu_rvalid), .op(op),
        .is_ebreak(is_ebreak), .regwrite_dec(regwrite_dec), .lsu_done(lsu_done),
        .ifu_req(ifu_req), .ir_we(ir_we), .lsu_req(lsu_req), .lsu_we(lsu_we),
        .pc_we(pc_we), .rf_we(rf_we), .halt(halt),
`ifdef NPC_PERF_CNT_EN
        .perf_cycles(perf_cycles), .perf_instret(perf_instret),
`endif
        .halt_code(halt_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ifu_rvalid = 1'b0; op = 7'd0;
        is_ebreak = 1'b0; regwrite_dec = 1'b0; lsu_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [8:0] outs();
        return {ifu_req, ir_we, lsu_req, lsu_we, pc_we, rf_we, halt, halt_code};
    endfunction

    initial begin
        do_reset();
        check("reset_outs", 64'(outs()), 64'd0);

        // addi: FETCH=1 DEC=2 EXE=3 WB=4 FETCH=5
        start = 1'b1; tick(); start = 1'b0;
        op = ADDI; regwrite_dec = 1'b1; ifu_rvalid = 1'b1; #1;
        check("c1_ifu_req", 64'(ifu_req), 64'd1);
        check("c1_ir_we", 64'(ir_we), 64'd1);
        tick(); ifu_rvalid = 1'b0; #1;
        check("c2_ir_we", 64'(ir_we), 64'd0);
        check("c2_ifu_req", 64'(ifu_req), 64'd0);
        tick();
        check("c3_pc_we", 64'(pc_we), 64'd0);
        tick();
        check("c4_pc_we", 64'(pc_we), 64'd1);
        check("c4_rf_we", 64'(rf_we), 64'd1);
        tick();
        check("c5_fetch", 64'(ifu_req), 64'd1);
        check("c5_pc_we", 64'(pc_we), 64'd0);

        // lw with lsu_done on third MEM cycle
        op = LW; ifu_rvalid = 1'b1; tick(); ifu_rvalid = 1'b0;
        tick();
        tick();
        check("lw_mem1_req", 64'(lsu_req), 64'd1);
        check("lw_mem1_we", 64'(lsu_we), 64'd0);
        tick();
        check("lw_mem2_req", 64'(lsu_req), 64'd1);
        tick();
        check("lw_mem3_req", 64'(lsu_req), 64'd1);
        lsu_done = 1'b1; tick(); lsu_done = 1'b0;
        check("lw_wb_req", 64'(lsu_req), 64'd0);
        check("lw_wb_pc_we", 64'(pc_we), 64'd1);
        check("lw_wb_rf_we", 64'(rf_we), 64'd1);
        tick();

        // sw: store qualifier, no register write
        op = SW; regwrite_dec = 1'b0; ifu_rvalid = 1'b1; tick(); ifu_rvalid = 1'b0;
        tick();
        tick();
        check("sw_mem_we", 64'(lsu_we), 64'd1);
        lsu_done = 1'b1; tick(); lsu_done = 1'b0;
        check("sw_wb_pc_we", 64'(pc_we), 64'd1);
        check("sw_wb_rf_we", 64'(rf_we), 64'd0);
        tick();

        // fetch watchdog: 8th FETCH cycle without rvalid halts
        check("to_f1", 64'(ifu_req), 64'd1);
        repeat (7) tick();
        check("to_f8_nohalt", 64'(halt), 64'd0);
        check("to_f8_ifu_req", 64'(ifu_req), 64'd1);
        tick();
        check("to_halt", 64'(halt), 64'd1);
        check("to_code", 64'(halt_code), 64'd3);
        check("to_ifu_req", 64'(ifu_req), 64'd0);

        // rvalid on the 8th FETCH cycle wins over expiry
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        op = ADDI;
        repeat (7) tick();
        ifu_rvalid = 1'b1; #1;
        check("race_ir_we", 64'(ir_we), 64'd1);
        tick(); ifu_rvalid = 1'b0;
        check("race_halt", 64'(halt), 64'd0);
        check("race_code", 64'(halt_code), 64'd0);
        check("race_dec", 64'(ifu_req), 64'd0);

        // async reset mid-MEM
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        op = SW; ifu_rvalid = 1'b1; tick(); ifu_rvalid = 1'b0;
        tick(); tick();
        check("mid_mem_req", 64'(lsu_req), 64'd1);
        #2 rst = 1'b1; #1;
        check("mid_rst_outs", 64'(outs()), 64'd0);
        tick(); rst = 1'b0;

        // ebreak halts with code 01; start afterwards is ignored
        start = 1'b1; tick(); start = 1'b0;
        op = SYSTEM; is_ebreak = 1'b1; ifu_rvalid = 1'b1; tick(); ifu_rvalid = 1'b0;
        tick(); is_ebreak = 1'b0;
        check("ebreak_halt", 64'(halt), 64'd1);
        check("ebreak_code", 64'(halt_code), 64'd1);
        start = 1'b1; tick(); tick(); start = 1'b0; tick();
        check("ebreak_sticky", 64'({halt, halt_code, ifu_req, pc_we}), 64'b1_01_0_0);

        // illegal opcode halts with code 10, never reaching WB
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        op = 7'b0000000; ifu_rvalid = 1'b1; tick(); ifu_rvalid = 1'b0;
        check("ill_dec_pc_we", 64'(pc_we), 64'd0);
        tick();
        check("ill_halt", 64'(halt), 64'd1);
        check("ill_code", 64'(halt_code), 64'd2);
        tick();
        check("ill_pc_we", 64'(pc_we), 64'd0);

        // ebreak has priority over illegal opcode
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        op = 7'b0000000; is_ebreak = 1'b1; ifu_rvalid = 1'b1; tick(); ifu_rvalid = 1'b0;
        tick(); is_ebreak = 1'b0;
        check("prio_code", 64'(halt_code), 64'd1);

`ifdef NPC_PERF_CNT_EN
        do_reset();
        check("perf_rst_cyc", perf_cycles, 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        op = ADDI; regwrite_dec = 1'b1; ifu_rvalid = 1'b1;
        repeat (12) tick();
        ifu_rvalid = 1'b0;
        check("perf_instret", perf_instret, 64'd3);
        check("perf_cycles", perf_cycles, 64'd12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
